apb_timer: RTL
==============

// Module: apb_timer
// PURPOSE
//  APB slave on one PSELx port of the AHB-to-APB bridge. Programmable
//  down-counter with 8-bit prescaler, auto-reload or one-shot mode, and a
//  level interrupt. Sits directly downstream of the bridge and consumes its
//  paddr/pwrite/pwdata/pstrb/psel/penable. Returns prdata/pready/pslverr.
// PARAMETERS
//  CNT_W    32  counter/LOAD width, 1..32; unused upper bits read 0
//  PRESC_W  8   prescaler width, 1..8
// PORTS
//  hclk     in   1      single clock; all flops on posedge
//  hreset   in   1      asynchronous, active-high reset
//  psel     in   1      slave select from bridge
//  penable  in   1      APB access phase
//  pwrite   in   1      1=write, 0=read
//  paddr    in   12     byte address; [1:0] ignored
//  pwdata   in   32     write data
//  pstrb    in   4      write byte strobes
//  pprot    in   3      accepted, ignored
//  prdata   out  32     read data
//  pready   out  1      transfer complete
//  pslverr  out  1      error response, valid when pready=1
//  irq      out  1      INTSTAT[0] & CTRL.IE
// BEHAVIOUR
//  Reset: all registers 0; prdata=0, pslverr=0, irq=0, pready=1 (0 if WAIT_EN).
//  Map (paddr[11:2]):
//   0x000 CTRL    rw  [0]EN [1]IE [2]ONESHOT
//   0x004 LOAD    rw  [CNT_W-1:0]
//   0x008 VALUE   ro  current count
//   0x00C PRESC   rw  [PRESC_W-1:0]
//   0x010 INTSTAT w1c [0]
//  - Access completes when psel & penable & pready. A write updates its
//    register in that cycle; each byte lane is written only if its pstrb bit
//    is set.
//  - prdata is registered. It is valid only in the completing cycle and is 0
//    otherwise.
//  - pslverr=1 in the completing cycle for an unmapped address or a write to
//    VALUE. No register changes; prdata=0.
//  - Prescaler: pcnt counts 0..PRESC. tick=1 when pcnt==PRESC and EN=1, then
//    pcnt wraps to 0. PRESC=0 gives a tick every cycle. pcnt holds at 0 while
//    EN=0.
//  - On tick: if VALUE!=0, VALUE decrements. If VALUE==0, INTSTAT set, and:
//    ONESHOT=0 -> VALUE<=LOAD; ONESHOT=1 -> EN<=0 and VALUE stays 0.
//  - Writing LOAD also loads VALUE in the same cycle. This overrides a
//    coincident tick.
//  - Writing EN 0->1 clears pcnt. The first tick comes PRESC+1 cycles later.
//  - INTSTAT: writing 1 to bit0 clears it. A set from a tick in the same
//    cycle wins over the clear.
//  - The counter wraps only via reload, never below 0.
//  - hreset asserted mid-transfer aborts it. All state returns to reset values.
// CONFIGURATION
//  APB_TIMER_WAIT_EN defined:
//   - Every access inserts exactly one wait state. In the first access-phase
//     cycle pready=0; the next cycle pready=1 and the access completes.
//   - Register updates occur only in the completing cycle.
//   - pready=0 whenever psel & penable is not in its second cycle.
//  Not defined:
//   - pready tied 1; zero-wait accesses.
// TESTING
//  1 Reset release -> all reads return 0. irq=0. pslverr=0 on mapped reads.
//  2 LOAD=3, PRESC=1, CTRL=0x3 -> VALUE reads 3,2,1,0 in 2-cycle steps.
//    Next tick: VALUE=3, INTSTAT=1, irq=1.
//  3 ONESHOT: CTRL=0x5, LOAD=2, PRESC=0 -> after 3 ticks INTSTAT=1, EN reads
//    0, VALUE stays 0.
//  4 Write LOAD=0xAABBCCDD with pstrb=4'b0101 over 0 -> LOAD reads 0x00BB00DD.
//  5 Read 0x020 / write VALUE -> pslverr=1, prdata=0, VALUE unchanged.
//  6 INTSTAT W1C coinciding with a zero-crossing tick -> INTSTAT stays 1.
//    With APB_TIMER_WAIT_EN: check pready=0 then 1 on every access.

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: APB down-counter timer with prescaler, one-shot/auto-reload and level irq.
// Define APB_TIMER_WAIT_EN to insert one wait state on every access.
module apb_timer #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    input  logic [2:0]  pprot,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq
);
    logic               en, ie, oneshot, intstat;
    logic [CNT_W-1:0]   load, value, load_new;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [9:0]         idx;
    logic [31:0]        wmask, load_merge, rdata;
    logic               access, bad, wr, tick, zero, prd;
    logic               unused;

    assign unused = &{1'b0, pprot, paddr[1:0]};
    assign idx    = paddr[11:2];

`ifdef APB_TIMER_WAIT_EN
    logic wt;
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) wt <= 1'b0;
        else        wt <= psel & penable & ~wt;
    assign pready = wt & psel & penable;
    assign prd    = psel & penable & ~wt;
`else
    assign pready = 1'b1;
    assign prd    = psel & ~penable;
`endif

    // prd marks the cycle before completion so the registered prdata lines up with it
    assign access  = psel & penable & pready;
    assign bad     = idx > 10'd4 || (pwrite && idx == 10'd2);
    assign wr      = access & pwrite & ~bad;
    assign pslverr = access & bad;
    assign tick    = en && pcnt == presc;
    assign zero    = value == '0;
    assign irq     = intstat & ie;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{pstrb[i]}};
        load_merge = (pwdata & wmask) | (32'(load) & ~wmask);
        load_new   = load_merge[CNT_W-1:0];
        rdata = idx == 10'd0 ? {29'b0, oneshot, ie, en} :
                idx == 10'd1 ? 32'(load) :
                idx == 10'd2 ? 32'(value) :
                idx == 10'd3 ? 32'(presc) :
                idx == 10'd4 ? {31'b0, intstat} : 32'b0;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
            intstat <= 1'b0;
            load    <= '0;
            value   <= '0;
            presc   <= '0;
            pcnt    <= '0;
            prdata  <= '0;
        end else begin
            pcnt <= (!en || tick) ? '0 : pcnt + PRESC_W'(1);
            // a zero-crossing tick beats a coincident W1C
            if (tick && zero)
                intstat <= 1'b1;
            else if (wr && idx == 10'd4 && pstrb[0] && pwdata[0])
                intstat <= 1'b0;
            if (wr && idx == 10'd1)
                value <= load_new;
            else if (tick)
                value <= zero ? (oneshot ? '0 : load) : value - CNT_W'(1);
            if (wr && idx == 10'd1)
                load <= load_new;
            if (wr && idx == 10'd3 && pstrb[0])
                presc <= pwdata[PRESC_W-1:0];
            if (wr && idx == 10'd0 && pstrb[0])
                {oneshot, ie, en} <= pwdata[2:0];
            else if (tick && zero && oneshot)
                en <= 1'b0;
            prdata <= (prd && !pwrite) ? rdata : '0;
        end
    end
endmodule
